// File: rtl/truth_table_sweeper.sv
// Clocked stimulus/capture stage for an N_IN-input combinational function:
// sweeps all input vectors, captures the 1-bit response and checks it against an expected table.
module truth_table_sweeper #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   exp_table,
    output logic [N_IN-1:0]      x_out,
    input  logic                 s_in,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   table_out,
    output logic                 mismatch,
    output logic [N_IN-1:0]      first_bad,
    output logic [N_IN:0]        ones_count
);

    localparam int TBL = 2**N_IN;
    localparam int CW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {IDLE, APPLY, CHECK} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   settle_cnt;
    logic [N_IN-1:0] idx;
    logic [TBL-1:0]  exp_reg;
    logic [TBL-1:0]  diff;
    logic [N_IN-1:0] bad_next;
    logic [N_IN:0]   ones_next;
    logic            sample;
    logic            last;

    assign sample = (state == APPLY) && (settle_cnt == CW'(SETTLE - 1));
    assign last   = (idx == {N_IN{1'b1}});
    assign busy   = (state != IDLE);
    assign x_out  = idx;
    assign diff   = table_out ^ exp_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = APPLY;
            APPLY:   if (sample && last) state_next = CHECK;
            CHECK:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Descending scan so the lowest differing index is the one left standing.
    always_comb begin
        bad_next  = '0;
        ones_next = '0;
        for (int i = TBL - 1; i >= 0; i--) begin
            if (diff[i]) bad_next = N_IN'(i);
        end
        for (int i = 0; i < TBL; i++) begin
            ones_next = ones_next + (N_IN+1)'(table_out[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
            idx        <= '0;
            exp_reg    <= '0;
            table_out  <= '0;
            done       <= 1'b0;
            mismatch   <= 1'b0;
            first_bad  <= '0;
            ones_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        exp_reg    <= exp_table;
                        table_out  <= '0;
                        idx        <= '0;
                        settle_cnt <= '0;
                        mismatch   <= 1'b0;
                        first_bad  <= '0;
                        ones_count <= '0;
                    end
                end
                APPLY: begin
                    if (sample) begin
                        table_out[idx] <= s_in;
                        settle_cnt     <= '0;
                        if (!last) idx <= idx + 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    mismatch   <= |diff;
                    first_bad  <= bad_next;
                    ones_count <= ones_next;
                    done       <= 1'b1;
                    idx        <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: two instances (SETTLE=1 and SETTLE=3) driving
// a modelled function; expected results are queued at start and compared at done.
module tb_truth_table_sweeper;

    localparam int MODE_NOR  = 0;
    localparam int MODE_XOR  = 1;
    localparam int MODE_ONES = 2;

    typedef struct packed {
        logic [3:0] tbl;
        logic       mm;
        logic [1:0] fb;
        logic [2:0] ones;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start1 = 1'b0, start3 = 1'b0;
    logic [3:0] exp1 = '0, exp3 = '0;
    logic       s1, s3;
    int         mode1 = MODE_NOR, mode3 = MODE_NOR;

    logic [1:0] x1, x3, fb1, fb3;
    logic       busy1, busy3, done1, done3, mm1, mm3;
    logic [3:0] tbl1, tbl3;
    logic [2:0] ones1, ones3;

    int   checks = 0;
    int   errors = 0;
    res_t sb[$];

    always #5 clk = ~clk;

    function automatic logic f(input int mode, input logic [1:0] x);
        case (mode)
            MODE_NOR: return ~(x[1] | x[0]);
            MODE_XOR: return x[1] ^ x[0];
            default:  return 1'b1;
        endcase
    endfunction

    always_comb s1 = f(mode1, x1);
    always_comb s3 = f(mode3, x3);

    truth_table_sweeper #(.N_IN(2), .SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .exp_table(exp1), .x_out(x1),
        .s_in(s1), .busy(busy1), .done(done1), .table_out(tbl1), .mismatch(mm1),
        .first_bad(fb1), .ones_count(ones1)
    );

    truth_table_sweeper #(.N_IN(2), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .exp_table(exp3), .x_out(x3),
        .s_in(s3), .busy(busy3), .done(done3), .table_out(tbl3), .mismatch(mm3),
        .first_bad(fb3), .ones_count(ones3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic res_t model(input int mode, input logic [3:0] expt);
        res_t r;
        bit   found = 0;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r.tbl[i] = f(mode, 2'(i));
            r.ones   = r.ones + 3'(r.tbl[i]);
            if (r.tbl[i] != expt[i] && !found) begin
                found = 1;
                r.fb  = 2'(i);
            end
        end
        r.mm = found;
        return r;
    endfunction

    // Entered at a negedge with the DUT idle; returns at the negedge of the done cycle.
    task automatic sweep(input int which, input int mode, input logic [3:0] expt,
                         input bit hold, input bit mid, input string tag);
        int         s;
        res_t       r;
        logic [1:0] xo;
        logic       bo, dn;
        s = (which != 0) ? 3 : 1;
        if (which != 0) begin mode3 = mode; exp3 = expt; start3 = 1'b1; end
        else            begin mode1 = mode; exp1 = expt; start1 = 1'b1; end
        sb.push_back(model(mode, expt));
        @(posedge clk);
        for (int c = 0; c <= 4 * s + 1; c++) begin
            @(negedge clk);
            if (c == 0) begin
                if (which != 0) begin exp3 = ~expt; if (!hold) start3 = 1'b0; end
                else            begin exp1 = ~expt; if (!hold) start1 = 1'b0; end
            end
            if (mid && c == 2) begin
                if (which != 0) start3 = 1'b1; else start1 = 1'b1;
            end
            if (mid && c == 3 && !hold) begin
                if (which != 0) start3 = 1'b0; else start1 = 1'b0;
            end
            xo = (which != 0) ? x3 : x1;
            bo = (which != 0) ? busy3 : busy1;
            dn = (which != 0) ? done3 : done1;
            if (c < 4 * s) begin
                chk({tag, " x_out"}, xo, c / s);
                chk({tag, " busy/done apply"}, {bo, dn}, 2'b10);
            end else if (c == 4 * s) begin
                chk({tag, " busy/done check"}, {bo, dn}, 2'b10);
            end else begin
                chk({tag, " busy/done end"}, {bo, dn}, 2'b01);
                chk({tag, " x_out end"}, xo, 0);
                if (sb.size() == 0) begin
                    chk({tag, " scoreboard empty"}, 1, 0);
                end else begin
                    r = sb.pop_front();
                    if (which != 0) begin
                        chk({tag, " table_out"}, tbl3, r.tbl);
                        chk({tag, " mismatch"}, mm3, r.mm);
                        chk({tag, " first_bad"}, fb3, r.fb);
                        chk({tag, " ones_count"}, ones3, r.ones);
                    end else begin
                        chk({tag, " table_out"}, tbl1, r.tbl);
                        chk({tag, " mismatch"}, mm1, r.mm);
                        chk({tag, " first_bad"}, fb1, r.fb);
                        chk({tag, " ones_count"}, ones1, r.ones);
                    end
                end
            end
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset x_out", x1, 0);
        chk("reset busy/done", {busy1, done1, busy3, done3}, 0);
        chk("reset results", {tbl1, mm1, fb1, ones1}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        sweep(0, MODE_NOR, 4'b0001, 0, 0, "nor_ok");
        chk("nor_ok literal table", tbl1, 4'b0001);
        sweep(0, MODE_NOR, 4'b0011, 0, 0, "nor_bad");
        chk("nor_bad literal first_bad", fb1, 1);
        sweep(1, MODE_XOR, 4'b0110, 0, 0, "xor_s3");
        chk("xor_s3 literal ones", ones3, 2);
        sweep(0, MODE_NOR, 4'b1001, 0, 0, "nor_bad3");
        sweep(0, MODE_NOR, 4'b1110, 0, 0, "nor_bad_all");

        // Reset while x_out = 10.
        mode1 = MODE_NOR; exp1 = 4'b0001; start1 = 1'b1;
        @(posedge clk);
        @(negedge clk); start1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre-reset x_out", x1, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset x_out", x1, 0);
        chk("async reset busy/done", {busy1, done1}, 0);
        chk("async reset results", {tbl1, mm1, fb1, ones1}, 0);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post-reset idle", {busy1, done1}, 0);
        end

        sweep(0, MODE_NOR, 4'b0001, 0, 0, "after_reset");
        sweep(0, MODE_XOR, 4'b0110, 0, 1, "mid_start");
        sweep(0, MODE_XOR, 4'b0110, 1, 0, "hold_a");
        sweep(0, MODE_NOR, 4'b0001, 0, 0, "hold_b");
        sweep(0, MODE_ONES, 4'b1111, 0, 0, "ones1");
        chk("ones1 literal ones", ones1, 4);
        sweep(1, MODE_ONES, 4'b1110, 0, 0, "ones3_bad0");
        repeat (3) @(negedge clk);
        chk("results hold", {tbl3, mm3, fb3, ones3}, {4'b1111, 1'b1, 2'd0, 3'd4});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequential stimulus-and-capture stage that sits directly upstream and downstream of a combinational function block such as `fxy`. It drives every input combination of an N-input function in ascending binary order, samples the function's 1-bit output after a settle interval, and assembles the full truth table. It then compares the captured table against an expected table and reports mismatch, first failing index, and count of ones. It replaces hand-written `#1`-stepped stimulus with a clocked, self-checking sweep.

## Interface
- `N_IN`, 2: number of function inputs; the table has 2**N_IN entries.
- `SETTLE`, 1: cycles each vector is held before sampling, ≥1.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a sweep; honoured only in IDLE.
- `exp_table`  in  2**N_IN  expected table, bit i = f(i); captured on the accepted start edge.
- `x_out`  out  N_IN  registered vector to the function under test; MSB is the first operand (x), LSB the last (y).
- `s_in`  in  1  function output; sampled only at capture edges.
- `busy`  out  1  high while the sweep is in progress.
- `done`  out  1  one-cycle pulse after the last capture.
- `table_out`  out  2**N_IN  captured table, bit i = s_in sampled while x_out = i.
- `mismatch`  out  1  table_out != exp_table; valid from done onward.
- `first_bad`  out  N_IN  lowest index where the tables differ; 0 when mismatch=0.
- `ones_count`  out  N_IN+1  number of 1 bits in table_out.

## Operation
- States: IDLE, APPLY, CHECK.
- IDLE: `x_out`=0 and `busy`=0. An edge with `start`=1 registers `exp_table`, clears `table_out`, sets `idx`=0, `x_out`=0 and `settle_cnt`=0, then enters APPLY.
- APPLY: `busy`=1. `settle_cnt` increments each edge. On the edge where `settle_cnt`==SETTLE-1:
  - `table_out[idx]` <= `s_in` and `settle_cnt` <= 0.
  - If `idx`==2**N_IN-1: enter CHECK.
  - Otherwise: `idx`++ and `x_out`++.
- CHECK: exactly one cycle, `busy`=1. It computes `mismatch`, `first_bad` and `ones_count` from the registered tables using a priority scan from index 0. On exit it pulses `done`, returns to IDLE and zeroes `x_out`.
- `table_out`, `mismatch`, `first_bad` and `ones_count` hold until the next accepted start.
- `start` is ignored in APPLY and CHECK. `start` held high continuously restarts the sweep on the first IDLE edge after `done`.
- Changes on `exp_table` outside the start edge have no effect.
- `x_out` never wraps: the sweep ends at the all-ones vector.

## Timing
- Reset (async assert, any state): state=IDLE; `x_out`, `busy`, `done`, `table_out`, `mismatch`, `first_bad`, `ones_count` and internal `idx`/`settle_cnt` are all 0.
- Reset mid-sweep discards the partial table. No `done` is produced.
- Start accepted at edge E0. Vector i is on `x_out` from E0+i·SETTLE and sampled at edge E0+(i+1)·SETTLE.
- CHECK occupies the cycle after edge E0+2**N_IN·SETTLE.
- `done` is high and `busy` low in the cycle after edge E0+2**N_IN·SETTLE+1. Total latency is 2**N_IN·SETTLE+1 edges from start to done.
- Results are stable and valid in the same cycle as `done`.
- `s_in` must settle within SETTLE cycles of an `x_out` change. This is a combinational path from the registered `x_out`.

## Test plan
- NOR function, N_IN=2, SETTLE=1, `exp_table`=4'b0001, start pulse → `x_out` = 00, 01, 10, 11 on consecutive cycles. `done` arrives 5 edges after start with `table_out`=0001, `mismatch`=0, `first_bad`=0, `ones_count`=1.
- Same NOR with `exp_table`=4'b0011 → `mismatch`=1, `first_bad`=1, `table_out`=0001.
- SETTLE=3, `s_in`=x_out[1]^x_out[0] → each vector held 3 cycles, `done` 13 edges after start, `table_out`=0110, `ones_count`=2.
- `rst_n` pulsed low while `x_out`=10 → all outputs 0 immediately, no `done`. A new start then runs a full clean sweep.
- `start` re-asserted while `busy`=1 → no effect on timing or result. `start` held high → back-to-back sweeps with one IDLE cycle between `done` and the next `x_out`=00.
- `s_in` tied 1, `exp_table`=4'b1111 → `table_out`=1111, `ones_count`=4 (N_IN+1 width boundary), `mismatch`=0.
